// File: rtl/c5_mult.sv
// c5 execute-stage iterative multiply/divide unit.
// Owns HI/LO; one radix-2 step per clock, 32 steps per operation.
module c5_mult #(
  parameter logic [31:0] P_DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [31:0] I_a,
  input  logic [31:0] I_b,
  input  logic [3:0]  I_mult_func,
  output logic [31:0] O_c_mult,
  output logic        O_pause
);

  localparam logic [3:0] F_MFLO  = 4'd1;
  localparam logic [3:0] F_MFHI  = 4'd2;
  localparam logic [3:0] F_MTLO  = 4'd3;
  localparam logic [3:0] F_MTHI  = 4'd4;
  localparam logic [3:0] F_MULTU = 4'd5;
  localparam logic [3:0] F_MULT  = 4'd6;
  localparam logic [3:0] F_DIVU  = 4'd7;
  localparam logic [3:0] F_DIV   = 4'd8;

  logic [31:0] hi, lo, opd, a_raw;
  logic [63:0] acc;
  logic [5:0]  count;
  logic        is_div, div0, neg_q, neg_r;

  logic [31:0] n_hi, n_lo, n_opd, n_a_raw;
  logic [63:0] n_acc;
  logic [5:0]  n_count;
  logic        n_is_div, n_div0, n_neg_q, n_neg_r;

  logic        busy;
  logic        is_mf;
  logic        sgn;
  logic        start_div;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [33:0] div_diff;
  logic [63:0] step;
  logic [63:0] prod;
  logic [31:0] q, r;
  logic [31:0] fin_hi, fin_lo;

  assign busy  = (count != 6'd0);
  assign is_mf = (I_mult_func == F_MFLO) || (I_mult_func == F_MFHI);
  assign O_pause = busy && is_mf;

  always_comb begin
    O_c_mult = 32'd0;
    if (I_mult_func == F_MFLO) O_c_mult = lo;
    else if (I_mult_func == F_MFHI) O_c_mult = hi;
  end

  assign sgn = (I_mult_func == F_MULT) || (I_mult_func == F_DIV);
  assign start_div = (I_mult_func == F_DIVU) || (I_mult_func == F_DIV);
  assign a_abs = (sgn && I_a[31]) ? (~I_a + 32'd1) : I_a;
  assign b_abs = (sgn && I_b[31]) ? (~I_b + 32'd1) : I_b;

  // multiply: upper half accumulates, lower half shifts the multiplier out
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opd : 32'd0)};
  // divide: restoring, remainder in upper half, quotient shifts in below
  assign div_top  = acc[63:31];
  assign div_diff = {1'b0, div_top} - {2'b00, opd};

  always_comb begin
    if (is_div) begin
      if (div_diff[33]) step = {div_top[31:0], acc[30:0], 1'b0};
      else step = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      step = {mul_sum, acc[31:1]};
    end
  end

  assign prod = neg_q ? (~step + 64'd1) : step;
  assign q = step[31:0];
  assign r = step[63:32];

  always_comb begin
    if (!is_div) begin
      fin_hi = prod[63:32];
      fin_lo = prod[31:0];
    end else if (div0) begin
      fin_hi = a_raw;
      fin_lo = P_DIV0_LO;
    end else begin
      fin_hi = neg_r ? (~r + 32'd1) : r;
      fin_lo = neg_q ? (~q + 32'd1) : q;
    end
  end

  always_comb begin
    n_hi     = hi;
    n_lo     = lo;
    n_acc    = acc;
    n_opd    = opd;
    n_a_raw  = a_raw;
    n_count  = count;
    n_is_div = is_div;
    n_div0   = div0;
    n_neg_q  = neg_q;
    n_neg_r  = neg_r;
    if (busy) begin
      n_acc   = step;
      n_count = count - 6'd1;
      if (count == 6'd1) begin
        n_hi = fin_hi;
        n_lo = fin_lo;
      end
    end
    // a new command discards any in-flight result, even a final step
    if (!O_pause) begin
      case (I_mult_func)
        F_MTLO: begin
          n_hi    = hi;
          n_lo    = I_a;
          n_count = 6'd0;
        end
        F_MTHI: begin
          n_hi    = I_a;
          n_lo    = lo;
          n_count = 6'd0;
        end
        F_MULTU, F_MULT, F_DIVU, F_DIV: begin
          n_hi     = hi;
          n_lo     = lo;
          n_count  = 6'd32;
          n_is_div = start_div;
          n_acc    = {32'd0, (start_div ? a_abs : b_abs)};
          n_opd    = start_div ? b_abs : a_abs;
          n_a_raw  = I_a;
          n_div0   = start_div && (I_b == 32'd0);
          n_neg_q  = sgn && (I_a[31] ^ I_b[31]);
          n_neg_r  = sgn && I_a[31];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      acc    <= 64'd0;
      opd    <= 32'd0;
      a_raw  <= 32'd0;
      count  <= 6'd0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      hi     <= n_hi;
      lo     <= n_lo;
      acc    <= n_acc;
      opd    <= n_opd;
      a_raw  <= n_a_raw;
      count  <= n_count;
      is_div <= n_is_div;
      div0   <= n_div0;
      neg_q  <= n_neg_q;
      neg_r  <= n_neg_r;
    end
  end

endmodule

// File: tb/tb_c5_mult.sv
// Scoreboard bench for c5_mult: MF reads queue expected values,
// a negedge monitor pops and compares when a read is presented.
module tb_c5_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  func = 4'd0;
  logic [31:0] c_mult;
  logic        pause;

  c5_mult dut (
    .I_clk(clk),
    .I_rst_n(rst_n),
    .I_a(a),
    .I_b(b),
    .I_mult_func(func),
    .O_c_mult(c_mult),
    .O_pause(pause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (rst_n && (func == 4'd1 || func == 4'd2) && !pause) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read got=%08h required=none", c_mult);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (c_mult !== e.v) begin
          n_bad++;
          $display("FAIL %s got=%08h required=%08h", e.nm, c_mult, e.v);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk);
    #1;
    func = f;
    a = x;
    b = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(4'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [3:0] f, input logic [31:0] ev,
                    input string nm, output int pc);
    exp_t e;
    bit done;
    @(posedge clk);
    #1;
    func = f;
    e.nm = nm;
    e.v = ev;
    sb.push_back(e);
    pc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (!pause) begin
        done = 1;
      end else begin
        pc++;
        if (pc > 40) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_timeout got=pause_stuck required=release", nm);
          void'(sb.pop_back());
          func = 4'd0;
          done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  int pc;

  initial begin
    idle(2);
    #1;
    rst_n = 1'b1;

    rd(4'd1, 32'h0, "reset_lo", pc);
    chk("reset_lo_pause", pc, 0);
    rd(4'd2, 32'h0, "reset_hi", pc);

    // reset in the middle of a MULTU
    issue(4'd5, 32'd7, 32'd9);
    idle(8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(4'd1, 32'h0, "rst_mid_lo", pc);
    chk("rst_mid_pause", pc, 0);
    rd(4'd2, 32'h0, "rst_mid_hi", pc);

    // MFLO right behind a MULTU stalls until the result lands
    issue(4'd5, 32'hFFFFFFFF, 32'd2);
    rd(4'd1, 32'hFFFFFFFE, "multu_lo", pc);
    chk("multu_pause_seen", int'(pc >= 31 && pc <= 32), 1);
    rd(4'd2, 32'h00000001, "multu_hi", pc);
    chk("multu_hi_nopause", pc, 0);

    issue(4'd6, 32'hFFFFFFFD, 32'd5);
    rd(4'd2, 32'hFFFFFFFF, "mult_neg_hi", pc);
    rd(4'd1, 32'hFFFFFFF1, "mult_neg_lo", pc);

    issue(4'd6, 32'hFFFFFFFE, 32'hFFFFFFFD);
    rd(4'd1, 32'd6, "mult_nn_lo", pc);
    rd(4'd2, 32'd0, "mult_nn_hi", pc);

    issue(4'd8, 32'hFFFFFFF9, 32'd2);
    rd(4'd1, 32'hFFFFFFFD, "div_neg_lo", pc);
    rd(4'd2, 32'hFFFFFFFF, "div_neg_hi", pc);

    issue(4'd7, 32'd7, 32'd2);
    rd(4'd1, 32'd3, "divu_lo", pc);
    rd(4'd2, 32'd1, "divu_hi", pc);

    issue(4'd7, 32'h1234, 32'd0);
    idle(3);
    rd(4'd1, 32'hFFFFFFFF, "div0_lo", pc);
    chk("div0_still_busy", int'(pc > 0), 1);
    rd(4'd2, 32'h00001234, "div0_hi", pc);

    issue(4'd8, 32'h80000000, 32'hFFFFFFFF);
    rd(4'd1, 32'h80000000, "div_ovf_lo", pc);
    rd(4'd2, 32'h00000000, "div_ovf_hi", pc);

    // a second start aborts the first
    issue(4'd5, 32'd3, 32'd4);
    idle(4);
    issue(4'd7, 32'd100, 32'd7);
    rd(4'd1, 32'd14, "abort_start_lo", pc);
    rd(4'd2, 32'd2, "abort_start_hi", pc);

    issue(4'd3, 32'hA5A5A5A5, 32'd0);
    rd(4'd1, 32'hA5A5A5A5, "mtlo", pc);
    chk("mtlo_pause", pc, 0);

    // MTHI mid-MULTU aborts it and leaves LO alone
    issue(4'd5, 32'd3, 32'd4);
    idle(3);
    issue(4'd4, 32'h55, 32'd0);
    rd(4'd2, 32'h55, "mthi_abort_hi", pc);
    chk("mthi_abort_idle", pc, 0);
    rd(4'd1, 32'hA5A5A5A5, "mthi_abort_lo", pc);
    idle(40);
    rd(4'd1, 32'hA5A5A5A5, "abort_late_lo", pc);
    rd(4'd2, 32'h55, "abort_late_hi", pc);

    idle(2);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/c5_mult.md
Name: c5_mult

Overview:
Iterative multiply/divide unit for the c5 CPU. It sits beside c5_alu in the execute stage and consumes the same operand buses (I_a/I_b). It holds the architectural HI/LO registers and computes 32x32 products and quotient/remainder over 32 clock cycles. It stalls the pipeline via O_pause when HI/LO are read before a result is ready.

Parameters:
P_DIV0_LO, 32'hFFFFFFFF, LO value written on any divide by zero.

Ports:
I_clk  input  1  system clock, all state on rising edge
I_rst_n  input  1  synchronous active-low reset
I_a  input  32  operand A (multiplicand / dividend / MTHI-MTLO data)
I_b  input  32  operand B (multiplier / divisor)
I_mult_func  input  4  0 none, 1 MFLO, 2 MFHI, 3 MTLO, 4 MTHI, 5 MULTU, 6 MULT, 7 DIVU, 8 DIV; 9-15 treated as none
O_c_mult  output  32  LO when func=1, HI when func=2, else 0 (combinational)
O_pause  output  1  stall request: busy AND func in {1,2} (combinational)

Behaviour:
- Reset (I_rst_n=0 at a rising edge): HI=0, LO=0, count=0, busy=0, internal sign flags cleared. O_pause=0 and O_c_mult=0 follow while func=0. Reset takes priority over all commands, including mid-operation aborts.
- State: IDLE (count=0) / BUSY (count 1..32). busy = (count != 0).
- Start (func 5-8, sampled at edge E0): latch |A| and |B| (abs only for 6/8), plus sign flags; count<=32. One radix-2 step per edge. At the edge where count goes 1->0, the final HI/LO are written, sign-corrected. Results are readable in the cycle after edge E0+32. During BUSY, HI/LO hold their old values.
- MULTU/MULT: the 64-bit product goes to {HI,LO}. For MULT, the 64-bit result is negated if sign(A) XOR sign(B).
- DIVU/DIV: quotient goes to LO, remainder to HI. For DIV, the quotient is negated if signs differ, and the remainder takes the sign of the dividend.
- Divide by zero (B=0, func 7 or 8): still takes 32 cycles; LO=P_DIV0_LO, HI=I_a as latched, with no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- MTLO/MTHI (3/4): the register is written with I_a at the edge; takes effect in 1 cycle.
- Commands are sampled only when O_pause=0. A start or MT command issued while BUSY aborts the running operation (count overwritten), then executes. Partial results are discarded.
- MFLO/MFHI while BUSY: O_pause=1 until the cycle after completion. O_c_mult then shows the new value. MF commands never modify state.
- Func none/9-15: no state change; BUSY continues counting.
- Arithmetic is modulo 2^32 per register; no overflow flags.

Test Plan:
- Reset mid-op: start MULTU 7*9, assert I_rst_n=0 at cycle 10 -> next cycle HI=LO=0, busy=0; MFLO returns 0, no pause.
- MULTU 0xFFFFFFFF*2, MFLO issued next cycle -> O_pause=1 for 31 cycles, then O_c_mult=0xFFFFFFFE; MFHI -> 0x00000001.
- MULT 0xFFFFFFFD(-3)*5 -> after 32 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0xA5A5A5A5 then MFLO -> 0xA5A5A5A5, O_pause=0. MULTU started, MTHI 0x55 at cycle 5 -> op aborted, HI=0x55, LO unchanged, busy=0.
